// File: rtl/cache_axi_bridge.sv
// -----------------------------------------------------------------------------
// cache_axi_bridge
// Purpose : AXI4 master for the cache request pipeline. Accepts one cache
//           request (load/store, block/word), runs the matching AXI4 read
//           (AR/R) or write (AW/W/B) transaction, returns read data and a
//           one-cycle task_finish pulse.
// Ports   :
//   clk, rstn                 clock, synchronous active-low reset
//   req[2:0]                  0 NONE, 1 LOAD_BLOCK, 2 LOAD_WORD,
//                             3 WRITE_BLOCK, 4 WRITE_WORD, others NONE
//   ad, cached                request address, cacheable attribute
//   wblock, wword, wword_en   store data / byte strobes
//   rword_en                  byte enables for LOAD_WORD (selects arsize)
//   ready                     one-cycle accept pulse
//   task_finish               one-cycle completion pulse
//   rblock, rword             assembled read block / read word
//   ar*, r*, aw*, w*, b*      AXI4 master channels (32-bit addr and data)
// -----------------------------------------------------------------------------
module cache_axi_bridge #(
   parameter int BLOCK_WORDS = 4,
   parameter int AXI_ID      = 0
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [2:0]                req,
   input  logic [31:0]               ad,
   input  logic                      cached,
   input  logic [32*BLOCK_WORDS-1:0] wblock,
   input  logic [31:0]               wword,
   input  logic [3:0]                wword_en,
   input  logic [3:0]                rword_en,
   output logic                      ready,
   output logic                      task_finish,
   output logic [32*BLOCK_WORDS-1:0] rblock,
   output logic [31:0]               rword,
   output logic [3:0]                arid,
   output logic [31:0]               araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic [3:0]                arcache,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [31:0]               rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [3:0]                awid,
   output logic [31:0]               awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic [3:0]                awcache,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [31:0]               wdata,
   output logic [3:0]                wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);

   localparam logic [2:0] REQ_LOAD_BLOCK  = 3'd1;
   localparam logic [2:0] REQ_LOAD_WORD   = 3'd2;
   localparam logic [2:0] REQ_WRITE_BLOCK = 3'd3;
   localparam logic [2:0] REQ_WRITE_WORD  = 3'd4;

   // Low address bits cleared for block operations (block-aligned burst).
   localparam logic [31:0] BLOCK_MASK = 32'(4*BLOCK_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_WR   = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   state_t                    state_r, state_s;
   logic [2:0]                req_r;
   logic [31:0]               addr_r;
   logic                      cached_r;
   logic [32*BLOCK_WORDS-1:0] wblock_r;
   logic [31:0]               wword_r;
   logic [3:0]                wword_en_r;
   logic [3:0]                rword_en_r;
   logic [IDX_W-1:0]          rk_r;
   logic [IDX_W-1:0]          wk_r;
   logic                      aw_done_r;
   logic                      w_done_r;
   logic                      ready_r;
   logic [32*BLOCK_WORDS-1:0] rblock_r;
   logic [31:0]               rword_r;

   logic                      req_valid_s;
   logic                      req_load_s;
   logic                      req_block_s;
   logic                      is_block_s;
   logic                      is_load_word_s;
   logic                      aw_hs_s;
   logic                      w_hs_s;
   logic                      aw_fin_s;
   logic                      w_fin_s;
   logic [31:0]               wdata_s;
   logic                      wlast_s;
   logic                      unused_resp_s;

   // Responses are not acted upon: error responses complete like OKAY.
   assign unused_resp_s = ^{rresp, bresp};

   // Narrowest transfer size covering the requested byte lanes.
   function automatic logic [2:0] size_from_en(input logic [3:0] en);
      logic [2:0] size;
      case (en)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
         4'b0011, 4'b1100:                   size = 3'd1;
         default:                            size = 3'd2;
      endcase
      return size;
   endfunction

   assign req_valid_s = (req >= REQ_LOAD_BLOCK) && (req <= REQ_WRITE_WORD);
   assign req_load_s  = (req == REQ_LOAD_BLOCK) || (req == REQ_LOAD_WORD);
   assign req_block_s = (req == REQ_LOAD_BLOCK) || (req == REQ_WRITE_BLOCK);

   assign is_block_s     = (req_r == REQ_LOAD_BLOCK) || (req_r == REQ_WRITE_BLOCK);
   assign is_load_word_s = (req_r == REQ_LOAD_WORD);

   assign aw_hs_s  = awvalid && awready;
   assign w_hs_s   = wvalid && wready;
   assign aw_fin_s = aw_done_r || aw_hs_s;
   assign w_fin_s  = w_done_r || (w_hs_s && wlast_s);

   // Write beat data / last flag selected by the beat counter.
   always_comb begin
      wdata_s = wword_r;
      wlast_s = 1'b1;
      if (is_block_s) begin
         wlast_s = (wk_r == IDX_W'(BLOCK_WORDS - 1));
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (wk_r == IDX_W'(i)) begin
               wdata_s = wblock_r[32*i +: 32];
            end else begin
               wdata_s = wdata_s;
            end
         end
      end else begin
         wdata_s = wword_r;
         wlast_s = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid_s) begin
               state_s = req_load_s ? ST_AR : ST_WR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_AR: begin
            if (arready) begin
               state_s = ST_R;
            end else begin
               state_s = ST_AR;
            end
         end
         ST_R: begin
            // rlast ends the burst regardless of how many beats were counted.
            if (rvalid && rlast) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_R;
            end
         end
         ST_WR: begin
            if (aw_fin_s && w_fin_s) begin
               state_s = ST_B;
            end else begin
               state_s = ST_WR;
            end
         end
         ST_B: begin
            if (bvalid) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_B;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Request capture, beat counters, channel-done flags and read data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_r      <= 3'd0;
         addr_r     <= 32'd0;
         cached_r   <= 1'b0;
         wblock_r   <= '0;
         wword_r    <= 32'd0;
         wword_en_r <= 4'd0;
         rword_en_r <= 4'd0;
         rk_r       <= '0;
         wk_r       <= '0;
         aw_done_r  <= 1'b0;
         w_done_r   <= 1'b0;
         ready_r    <= 1'b0;
         rblock_r   <= '0;
         rword_r    <= 32'd0;
      end else begin
         ready_r <= (state_r == ST_IDLE) && req_valid_s;
         if ((state_r == ST_IDLE) && req_valid_s) begin
            req_r      <= req;
            addr_r     <= req_block_s ? (ad & ~BLOCK_MASK) : ad;
            cached_r   <= cached;
            wblock_r   <= wblock;
            wword_r    <= wword;
            wword_en_r <= wword_en;
            rword_en_r <= rword_en;
            rk_r       <= '0;
            wk_r       <= '0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
         end
         if ((state_r == ST_R) && rvalid) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
               if (rk_r == IDX_W'(i)) begin
                  rblock_r[32*i +: 32] <= rdata;
               end
            end
            rk_r <= rk_r + IDX_W'(1);
            if (is_load_word_s) begin
               rword_r <= rdata;
            end
         end
         if (state_r == ST_WR) begin
            if (aw_hs_s) begin
               aw_done_r <= 1'b1;
            end
            if (w_hs_s) begin
               if (wlast_s) begin
                  w_done_r <= 1'b1;
               end else begin
                  wk_r <= wk_r + IDX_W'(1);
               end
            end
         end
      end
   end

   assign ready       = ready_r;
   assign task_finish = (state_r == ST_DONE);
   assign rblock      = rblock_r;
   assign rword       = rword_r;

   assign arid    = 4'(AXI_ID);
   assign araddr  = addr_r;
   assign arlen   = is_block_s ? 8'(BLOCK_WORDS - 1) : 8'd0;
   assign arsize  = is_block_s ? 3'd2 : size_from_en(rword_en_r);
   assign arburst = 2'b01;
   assign arcache = cached_r ? 4'b1111 : 4'b0000;
   assign arvalid = (state_r == ST_AR);
   assign rready  = (state_r == ST_R);

   assign awid    = 4'(AXI_ID);
   assign awaddr  = addr_r;
   assign awlen   = is_block_s ? 8'(BLOCK_WORDS - 1) : 8'd0;
   assign awsize  = 3'd2;
   assign awburst = 2'b01;
   assign awcache = cached_r ? 4'b1111 : 4'b0000;
   assign awvalid = (state_r == ST_WR) && !aw_done_r;

   assign wdata  = wdata_s;
   assign wstrb  = is_block_s ? 4'hF : wword_en_r;
   assign wlast  = wlast_s;
   assign wvalid = (state_r == ST_WR) && !w_done_r;
   assign bready = (state_r == ST_B);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_cache_axi_bridge
// Self-checking bench for cache_axi_bridge: a behavioural AXI slave checks the
// request channels against expectation queues, and request completion checks
// read data against a reference model of rblock/rword.
// -----------------------------------------------------------------------------
module tb_cache_axi_bridge;

   localparam int BW = 4;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [2:0]     req;
   logic [31:0]    ad;
   logic           cached;
   logic [32*BW-1:0] wblock;
   logic [31:0]    wword;
   logic [3:0]     wword_en, rword_en;
   logic           ready, task_finish;
   logic [32*BW-1:0] rblock;
   logic [31:0]    rword;
   logic [3:0]     arid, awid;
   logic [31:0]    araddr, awaddr;
   logic [7:0]     arlen, awlen;
   logic [2:0]     arsize, awsize;
   logic [1:0]     arburst, awburst;
   logic [3:0]     arcache, awcache;
   logic           arvalid, arready;
   logic [31:0]    rdata;
   logic [1:0]     rresp;
   logic           rlast, rvalid, rready;
   logic           awvalid, awready;
   logic [31:0]    wdata;
   logic [3:0]     wstrb;
   logic           wlast, wvalid, wready;
   logic [1:0]     bresp;
   logic           bvalid, bready;

   cache_axi_bridge #(.BLOCK_WORDS(BW), .AXI_ID(0)) dut (
      .clk(clk), .rstn(rstn), .req(req), .ad(ad), .cached(cached),
      .wblock(wblock), .wword(wword), .wword_en(wword_en), .rword_en(rword_en),
      .ready(ready), .task_finish(task_finish), .rblock(rblock), .rword(rword),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awcache(awcache), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   // Scoreboard queues and slave configuration.
   logic [127:0] exp_ar[$], exp_aw[$], exp_w[$], exp_rd_blk[$], exp_rd_word[$];
   logic [31:0]  rd_q[$];
   int           aw_delay = 0;
   int           r_beats_cfg = 0;
   logic [1:0]   r_resp_cfg = 2'b00;
   logic [1:0]   b_resp_cfg = 2'b00;
   int           rd_beats = 0;
   int           w_beats_done = 0;
   int           w_beats_at_aw = 0;
   int           aw_hs_cyc = 0;
   int           w_hs_cyc = 0;
   int           last_hs_cyc = 0;
   logic         b_done = 1'b0;

   logic [32*BW-1:0] model_rblock = '0;
   logic [31:0]      model_rword = 32'd0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pack_a(input logic [3:0] id, input logic [31:0] a,
                                           input logic [7:0] l, input logic [2:0] s,
                                           input logic [1:0] b, input logic [3:0] c);
      return {75'd0, id, a, l, s, b, c};
   endfunction

   // ---------------- AXI read slave ----------------
   task automatic slave_read();
      int nb;
      int n;
      logic [127:0] e;
      if (exp_ar.size() == 0) begin
         check_eq("ar_unexpected", 1'b1, 1'b0);
         e = '0;
      end else begin
         e = exp_ar.pop_front();
      end
      check_eq("ar_fields", pack_a(arid, araddr, arlen, arsize, arburst, arcache), e);
      nb = (r_beats_cfg != 0) ? r_beats_cfg : int'(arlen) + 1;
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      rd_beats = 0;
      for (int b = 0; b < nb; b++) begin
         n = 0;
         rvalid = 1'b1;
         rlast  = (b == nb - 1);
         rresp  = r_resp_cfg;
         rdata  = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hBAD0_0000;
         @(negedge clk);
         while (rready !== 1'b1 && rstn === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (rstn !== 1'b1) break;
         if (n >= 100) begin
            check_eq("r_timeout", 1'b0, 1'b1);
            break;
         end
         if (rlast) last_hs_cyc = cyc + 1;
         @(posedge clk); #1;
         rd_beats++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
   endtask

   initial begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (arvalid === 1'b1 && rstn === 1'b1) slave_read();
      end
   end

   // ---------------- AXI write slave ----------------
   task automatic slave_aw();
      int n;
      logic [127:0] e;
      n = 0;
      while (awvalid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         check_eq("aw_timeout", 1'b0, 1'b1);
         return;
      end
      repeat (aw_delay) @(negedge clk);
      check_eq("aw_held", awvalid, 1'b1);
      e = (exp_aw.size() != 0) ? exp_aw.pop_front() : '0;
      check_eq("aw_fields", pack_a(awid, awaddr, awlen, awsize, awburst, awcache), e);
      w_beats_at_aw = w_beats_done;
      aw_hs_cyc = cyc + 1;
      awready = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0;
   endtask

   task automatic slave_w();
      int nb;
      int n;
      logic [127:0] e;
      nb = (exp_w.size() != 0) ? exp_w.size() : 1;
      for (int b = 0; b < nb; b++) begin
         n = 0;
         while (wvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            check_eq("w_timeout", 1'b0, 1'b1);
            break;
         end
         e = (exp_w.size() != 0) ? exp_w.pop_front() : '0;
         check_eq("w_beat", {91'd0, wdata, wstrb, wlast}, e);
         if (b == 0) w_hs_cyc = cyc + 1;
         wready = 1'b1;
         @(posedge clk); #1;
         wready = 1'b0;
         w_beats_done++;
         @(negedge clk);
      end
   endtask

   task automatic slave_b();
      int n;
      n = 0;
      bvalid = 1'b1;
      bresp  = b_resp_cfg;
      while (bready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         check_eq("b_timeout", 1'b0, 1'b1);
      end else begin
         last_hs_cyc = cyc + 1;
         b_done = 1'b1;
         @(posedge clk); #1;
      end
      bvalid = 1'b0;
   endtask

   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      forever begin
         @(negedge clk);
         if (rstn === 1'b1 && (awvalid === 1'b1 || wvalid === 1'b1)) begin
            b_done = 1'b0;
            w_beats_done = 0;
            fork
               slave_aw();
               slave_w();
            join
            slave_b();
         end
      end
   end

   // ---------------- request driver / completion checker ----------------
   task automatic push_exp_rd();
      exp_rd_blk.push_back({{(128-32*BW){1'b0}}, model_rblock});
      exp_rd_word.push_back({96'd0, model_rword});
   endtask

   task automatic issue(input logic [2:0] r, input logic [31:0] a, input logic c,
                        input logic [3:0] ren, input logic [3:0] wen,
                        input logic [31:0] ww, input logic [32*BW-1:0] wb);
      @(posedge clk); #1;
      req = r; ad = a; cached = c; rword_en = ren; wword_en = wen; wword = ww; wblock = wb;
      @(posedge clk); #1;
      req = 3'd0;
      @(negedge clk);
      check_eq("ready_pulse", ready, 1'b1);
      @(negedge clk);
      check_eq("ready_single", ready, 1'b0);
   endtask

   task automatic wait_finish(input string tag);
      int n;
      logic [127:0] eb, ew;
      n = 0;
      while (task_finish !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_finish_seen"}, (n < 200), 1'b1);
      check_eq({tag, "_finish_cycle"}, cyc, last_hs_cyc);
      @(negedge clk);
      check_eq({tag, "_finish_single"}, task_finish, 1'b0);
      eb = (exp_rd_blk.size() != 0) ? exp_rd_blk.pop_front() : '0;
      ew = (exp_rd_word.size() != 0) ? exp_rd_word.pop_front() : '0;
      check_eq({tag, "_rblock"}, rblock, eb);
      check_eq({tag, "_rword"}, rword, ew);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      req = 3'd0; ad = 32'd0; cached = 1'b0; wblock = '0; wword = 32'd0;
      wword_en = 4'd0; rword_en = 4'd0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_ctrl", {ready, task_finish, arvalid, rready, awvalid, wvalid, bready}, 7'd0);
      check_eq("reset_rblock", rblock, 128'd0);
      check_eq("reset_rword", rword, 32'd0);
      #1 rstn = 1'b1;

      // LOAD_BLOCK, cached, unaligned address
      rd_q.push_back(32'h11); rd_q.push_back(32'h22); rd_q.push_back(32'h33); rd_q.push_back(32'h44);
      exp_ar.push_back(pack_a(4'd0, 32'h1C00_0010, 8'd3, 3'd2, 2'b01, 4'hF));
      model_rblock = {32'h44, 32'h33, 32'h22, 32'h11};
      push_exp_rd();
      issue(3'd1, 32'h1C00_0014, 1'b1, 4'hF, 4'h0, 32'd0, '0);
      wait_finish("load_block");

      // LOAD_WORD, half-word enables, uncached
      rd_q.push_back(32'hCAFE_F00D);
      exp_ar.push_back(pack_a(4'd0, 32'hBFAF_8002, 8'd0, 3'd1, 2'b01, 4'h0));
      model_rblock[31:0] = 32'hCAFE_F00D;
      model_rword = 32'hCAFE_F00D;
      push_exp_rd();
      issue(3'd2, 32'hBFAF_8002, 1'b0, 4'b1100, 4'h0, 32'd0, '0);
      wait_finish("load_word_half");

      // LOAD_WORD, single byte, SLVERR response
      r_resp_cfg = 2'b10;
      rd_q.push_back(32'h0000_00A5);
      exp_ar.push_back(pack_a(4'd0, 32'h0000_0101, 8'd0, 3'd0, 2'b01, 4'hF));
      model_rblock[31:0] = 32'h0000_00A5;
      model_rword = 32'h0000_00A5;
      push_exp_rd();
      issue(3'd2, 32'h0000_0101, 1'b1, 4'b0001, 4'h0, 32'd0, '0);
      wait_finish("load_word_slverr");
      r_resp_cfg = 2'b00;

      // LOAD_WORD, full word
      rd_q.push_back(32'h1234_5678);
      exp_ar.push_back(pack_a(4'd0, 32'h2000_0008, 8'd0, 3'd2, 2'b01, 4'h0));
      model_rblock[31:0] = 32'h1234_5678;
      model_rword = 32'h1234_5678;
      push_exp_rd();
      issue(3'd2, 32'h2000_0008, 1'b0, 4'b1111, 4'h0, 32'd0, '0);
      wait_finish("load_word_full");

      // WRITE_BLOCK with awready delayed 5 cycles
      aw_delay = 5;
      exp_aw.push_back(pack_a(4'd0, 32'h8000_0030, 8'd3, 3'd2, 2'b01, 4'hF));
      for (int i = 0; i < BW; i++) begin
         exp_w.push_back({91'd0, 32'hA000_0000 + 32'(i), 4'hF, (i == BW - 1)});
      end
      push_exp_rd();
      issue(3'd3, 32'h8000_003C, 1'b1, 4'h0, 4'h0, 32'd0,
            {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
      wait_finish("write_block");
      check_eq("wb_w_before_aw", w_beats_at_aw, BW);
      check_eq("wb_b_done", b_done, 1'b1);
      aw_delay = 0;

      // WRITE_WORD, AW and W accepted in the same cycle, DECERR response
      b_resp_cfg = 2'b11;
      exp_aw.push_back(pack_a(4'd0, 32'h1000_0006, 8'd0, 3'd2, 2'b01, 4'h0));
      exp_w.push_back({91'd0, 32'hDEAD_BEEF, 4'b0011, 1'b1});
      push_exp_rd();
      issue(3'd4, 32'h1000_0006, 1'b0, 4'h0, 4'b0011, 32'hDEAD_BEEF, '0);
      wait_finish("write_word");
      check_eq("ww_same_cycle", aw_hs_cyc, w_hs_cyc);
      check_eq("ww_b_done", b_done, 1'b1);
      b_resp_cfg = 2'b00;

      // LOAD_BLOCK ended early by rlast after two beats
      r_beats_cfg = 2;
      rd_q.push_back(32'h55); rd_q.push_back(32'h66);
      exp_ar.push_back(pack_a(4'd0, 32'h0000_1230, 8'd3, 3'd2, 2'b01, 4'h0));
      model_rblock[63:0] = {32'h66, 32'h55};
      push_exp_rd();
      issue(3'd1, 32'h0000_1238, 1'b0, 4'h0, 4'h0, 32'd0, '0);
      wait_finish("load_block_short");
      r_beats_cfg = 0;

      // Reset in the middle of a read burst
      rd_beats = 0;
      rd_q.push_back(32'h71); rd_q.push_back(32'h72); rd_q.push_back(32'h73); rd_q.push_back(32'h74);
      exp_ar.push_back(pack_a(4'd0, 32'h3000_0000, 8'd3, 3'd2, 2'b01, 4'hF));
      issue(3'd1, 32'h3000_0004, 1'b1, 4'h0, 4'h0, 32'd0, '0);
      begin
         int n;
         n = 0;
         while (rd_beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check_eq("midr_beats_seen", (n < 100), 1'b1);
      end
      #1 rstn = 1'b0;
      @(negedge clk);
      check_eq("midr_reset_ctrl", {ready, task_finish, arvalid, rready, awvalid, wvalid, bready}, 7'd0);
      check_eq("midr_reset_rblock", rblock, 128'd0);
      @(negedge clk);
      #1 rstn = 1'b1;
      rd_q.delete();
      exp_ar.delete();
      model_rblock = '0;
      model_rword = 32'd0;

      // Clean LOAD_BLOCK after reset
      rd_q.push_back(32'h1); rd_q.push_back(32'h2); rd_q.push_back(32'h3); rd_q.push_back(32'h4);
      exp_ar.push_back(pack_a(4'd0, 32'h4000_0000, 8'd3, 3'd2, 2'b01, 4'hF));
      model_rblock = {32'h4, 32'h3, 32'h2, 32'h1};
      push_exp_rd();
      issue(3'd1, 32'h4000_000C, 1'b1, 4'h0, 4'h0, 32'd0, '0);
      wait_finish("post_reset_load");

      check_eq("ar_queue_drained", exp_ar.size(), 0);
      check_eq("w_queue_drained", exp_w.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
